// File: rtl/core_alu_pkg.sv
// Shared ALU opcodes, status-flag bit positions and per-op flag-affect table.
package core_alu_pkg;

    typedef enum logic [3:0] {
        control_nop     = 4'd0,
        control_adc     = 4'd1,
        control_sbc     = 4'd2,
        control_and     = 4'd3,
        control_ora     = 4'd4,
        control_eor     = 4'd5,
        control_asl     = 4'd6,
        control_lsr     = 4'd7,
        control_rol     = 4'd8,
        control_ror     = 4'd9,
        control_inc     = 4'd10,
        control_dec     = 4'd11,
        control_cmp     = 4'd12,
        control_bit     = 4'd13,
        control_ld      = 4'd14,
        control_nop_alt = 4'd15
    } control_type;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_I = 2;
    localparam int unsigned FLAG_D = 3;
    localparam int unsigned FLAG_B = 4;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_N = 7;

    // Bit positions inside the 4-bit {N,V,Z,C} mask/flag bundle
    localparam int unsigned MSK_C = 0;
    localparam int unsigned MSK_Z = 1;
    localparam int unsigned MSK_V = 2;
    localparam int unsigned MSK_N = 3;

    function automatic logic [3:0] flag_affect(control_type op);
        logic [3:0] aff;
        aff = 4'b0000;
        unique case (op)
            control_adc, control_sbc: aff = 4'b1111;
            control_and, control_ora, control_eor,
            control_inc, control_dec, control_ld: aff = 4'b1010;
            control_asl, control_lsr, control_rol,
            control_ror, control_cmp: aff = 4'b1011;
            control_bit: aff = 4'b1110;
            default: aff = 4'b0000;
        endcase
        return aff;
    endfunction

endpackage

// File: rtl/core_alu_unit_register.sv
// Enable-gated register with asynchronous active-low clear to zero.
module core_alu_unit_register #(
    parameter int W = 8
) (
    input  logic         I_clock,
    input  logic         I_reset,
    input  logic         I_enable,
    input  logic [W-1:0] I_data,
    output logic [W-1:0] O_data
);

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            O_data <= '0;
        end else if (I_enable) begin
            O_data <= I_data;
        end
    end

endmodule

// File: rtl/core_alu_unit.sv
// 8-bit 2A03-style ALU with per-flag write mask.
// Define CORE_ALU_OUTREG_EN for an enable-gated registered output stage.
module core_alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             I_clock,
    input  logic             I_reset,
    input  logic             I_enable,
    input  logic [3:0]       I_control,
    input  logic [3:0]       I_mask_p,
    input  logic [WIDTH-1:0] I_lhs,
    input  logic [WIDTH-1:0] I_rhs,
    input  logic             I_carry,
    input  logic             I_overflow,
    input  logic             I_sign,
    input  logic             I_zero,
    output logic [WIDTH-1:0] O_result,
    output logic             O_carry,
    output logic             O_overflow,
    output logic             O_sign,
    output logic             O_zero
);

    import core_alu_pkg::*;

    control_type      op;
    logic [WIDTH-1:0] op2;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic [3:0]       fl_in;
    logic [3:0]       calc;
    logic [3:0]       upd;
    logic [3:0]       fl_out;

    assign op    = control_type'(I_control);
    assign fl_in = {I_sign, I_overflow, I_zero, I_carry};

    // cmp reuses the adder as lhs + ~rhs + 1 so C is the no-borrow bit
    assign op2 = (op == control_sbc || op == control_cmp) ? ~I_rhs : I_rhs;
    assign cin = (op == control_cmp) ? 1'b1 : I_carry;
    assign sum = {1'b0, I_lhs} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        res  = I_lhs;
        calc = fl_in;
        unique case (op)
            control_adc, control_sbc: begin
                res         = sum[WIDTH-1:0];
                calc[MSK_C] = sum[WIDTH];
                calc[MSK_V] = ~(I_lhs[WIDTH-1] ^ op2[WIDTH-1])
                            & (I_lhs[WIDTH-1] ^ sum[WIDTH-1]);
            end
            control_and: res = I_lhs & I_rhs;
            control_ora: res = I_lhs | I_rhs;
            control_eor: res = I_lhs ^ I_rhs;
            control_asl: begin
                res         = {I_lhs[WIDTH-2:0], 1'b0};
                calc[MSK_C] = I_lhs[WIDTH-1];
            end
            control_lsr: begin
                res         = {1'b0, I_lhs[WIDTH-1:1]};
                calc[MSK_C] = I_lhs[0];
            end
            control_rol: begin
                res         = {I_lhs[WIDTH-2:0], I_carry};
                calc[MSK_C] = I_lhs[WIDTH-1];
            end
            control_ror: begin
                res         = {I_carry, I_lhs[WIDTH-1:1]};
                calc[MSK_C] = I_lhs[0];
            end
            control_inc: res = I_lhs + WIDTH'(1);
            control_dec: res = I_lhs - WIDTH'(1);
            control_ld:  res = I_rhs;
            default: res = I_lhs;
        endcase

        unique case (op)
            control_cmp: begin
                calc[MSK_C] = sum[WIDTH];
                calc[MSK_N] = sum[WIDTH-1];
                calc[MSK_Z] = (I_lhs == I_rhs);
            end
            control_bit: begin
                calc[MSK_Z] = ((I_lhs & I_rhs) == '0);
                calc[MSK_N] = I_rhs[WIDTH-1];
                calc[MSK_V] = I_rhs[WIDTH-2];
            end
            default: begin
                calc[MSK_N] = res[WIDTH-1];
                calc[MSK_Z] = (res == '0);
            end
        endcase
    end

    assign upd    = I_mask_p & flag_affect(op);
    assign fl_out = (upd & calc) | (~upd & fl_in);

`ifdef CORE_ALU_OUTREG_EN
    logic [3:0] fl_q;

    core_alu_unit_register #(.W(WIDTH)) u_res_reg (
        .I_clock  (I_clock),
        .I_reset  (I_reset),
        .I_enable (I_enable),
        .I_data   (res),
        .O_data   (O_result)
    );

    core_alu_unit_register #(.W(4)) u_flag_reg (
        .I_clock  (I_clock),
        .I_reset  (I_reset),
        .I_enable (I_enable),
        .I_data   (fl_out),
        .O_data   (fl_q)
    );

    assign {O_sign, O_overflow, O_zero, O_carry} = fl_q;
`else
    logic unused_ctl;
    assign unused_ctl = ^{I_clock, I_reset, I_enable};

    assign O_result = res;
    assign {O_sign, O_overflow, O_zero, O_carry} = fl_out;
`endif

endmodule

// File: tb/tb_core_alu_unit.sv
// Self-checking bench for core_alu_unit: vector table, random model, latency corners.
module tb_core_alu_unit;

    import core_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic [3:0] ctrl = '0;
    logic [3:0] mask = '0;
    logic [7:0] lhs = '0;
    logic [7:0] rhs = '0;
    logic       c_in = 1'b0;
    logic       v_in = 1'b0;
    logic       n_in = 1'b0;
    logic       z_in = 1'b0;
    logic [7:0] result;
    logic       c_out;
    logic       v_out;
    logic       n_out;
    logic       z_out;

    always #5 clk = ~clk;

    core_alu_unit #(.WIDTH(8)) dut (
        .I_clock    (clk),
        .I_reset    (rst_n),
        .I_enable   (en),
        .I_control  (ctrl),
        .I_mask_p   (mask),
        .I_lhs      (lhs),
        .I_rhs      (rhs),
        .I_carry    (c_in),
        .I_overflow (v_in),
        .I_sign     (n_in),
        .I_zero     (z_in),
        .O_result   (result),
        .O_carry    (c_out),
        .O_overflow (v_out),
        .O_sign     (n_out),
        .O_zero     (z_out)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] fl;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] mask;
        logic [7:0] lhs;
        logic [7:0] rhs;
        logic [3:0] fl;
        logic [7:0] res;
        logic [3:0] efl;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[23];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic exp_t dut_out();
        return {result, n_out, v_out, z_out, c_out};
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got res=%h nvzc=%b, want res=%h nvzc=%b",
                     name, act.res, act.fl, exp.res, exp.fl);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] m,
                         input logic [7:0] l, input logic [7:0] r,
                         input logic [3:0] fl);
        ctrl = op;
        mask = m;
        lhs  = l;
        rhs  = r;
        {n_in, v_in, z_in, c_in} = fl;
    endtask

    task automatic settle();
`ifdef CORE_ALU_OUTREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic apply(input string name, input logic [3:0] op,
                         input logic [3:0] m, input logic [7:0] l,
                         input logic [7:0] r, input logic [3:0] fl,
                         input exp_t e);
        exp_t want;
        @(negedge clk);
        drive(op, m, l, r, fl);
        sb.push_back(e);
        settle();
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = sb.pop_front();
            check(name, dut_out(), want);
        end
    endtask

    // Reference model written with signed/unsigned integer arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [3:0] m,
                                   input logic [7:0] l, input logic [7:0] r,
                                   input logic [3:0] fl);
        int         ul, ur, sl, sr, ci, s, ns;
        logic [7:0] res;
        logic [3:0] full;
        logic [3:0] aff;
        exp_t       e;
        ul = int'(l);
        ur = int'(r);
        sl = (ul > 127) ? ul - 256 : ul;
        sr = (ur > 127) ? ur - 256 : ur;
        ci = int'(fl[0]);
        res = l;
        full = fl;
        aff = 4'b0000;
        case (op)
            4'd1: begin
                s = ul + ur + ci;
                ns = sl + sr + ci;
                res = 8'(s);
                full[0] = (s > 255);
                full[2] = (ns > 127) || (ns < -128);
                aff = 4'b1111;
            end
            4'd2: begin
                s = ul - ur - (1 - ci);
                ns = sl - sr - (1 - ci);
                res = 8'(s);
                full[0] = (s >= 0);
                full[2] = (ns > 127) || (ns < -128);
                aff = 4'b1111;
            end
            4'd3: begin res = l & r; aff = 4'b1010; end
            4'd4: begin res = l | r; aff = 4'b1010; end
            4'd5: begin res = l ^ r; aff = 4'b1010; end
            4'd6: begin res = 8'(ul * 2); full[0] = (ul >= 128); aff = 4'b1011; end
            4'd7: begin res = 8'(ul / 2); full[0] = (ul % 2 == 1); aff = 4'b1011; end
            4'd8: begin res = 8'(ul * 2 + ci); full[0] = (ul >= 128); aff = 4'b1011; end
            4'd9: begin res = 8'(ul / 2 + ci * 128); full[0] = (ul % 2 == 1); aff = 4'b1011; end
            4'd10: begin res = 8'(ul + 1); aff = 4'b1010; end
            4'd11: begin res = 8'(ul + 255); aff = 4'b1010; end
            4'd14: begin res = r; aff = 4'b1010; end
            default: ;
        endcase
        full[3] = (res >= 8'h80);
        full[1] = (res == 8'h00);
        if (op == 4'd12) begin
            s = ul - ur;
            full[0] = (ul >= ur);
            full[1] = (ul == ur);
            full[3] = ((s & 8'h80) != 0);
            aff = 4'b1011;
        end
        if (op == 4'd13) begin
            full[1] = ((l & r) == 8'h00);
            full[3] = r[7];
            full[2] = r[6];
            aff = 4'b1110;
        end
        e.res = res;
        e.fl  = (full & m & aff) | (fl & ~(m & aff));
        return e;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{4'd1,  4'hF, 8'h50, 8'h50, 4'b0000, 8'hA0, 4'b1100};
        vecs[1]  = '{4'd2,  4'hF, 8'h00, 8'h01, 4'b0001, 8'hFF, 4'b1000};
        vecs[2]  = '{4'd12, 4'hF, 8'h40, 8'h40, 4'b0000, 8'h40, 4'b0011};
        vecs[3]  = '{4'd9,  4'hF, 8'h01, 8'h00, 4'b0001, 8'h80, 4'b1001};
        vecs[4]  = '{4'd6,  4'hF, 8'h80, 8'h00, 4'b0000, 8'h00, 4'b0011};
        vecs[5]  = '{4'd13, 4'hF, 8'h0F, 8'hC0, 4'b0001, 8'h0F, 4'b1111};
        vecs[6]  = '{4'd13, 4'h0, 8'h0F, 8'hC0, 4'b0101, 8'h0F, 4'b0101};
        vecs[7]  = '{4'd10, 4'hF, 8'hFF, 8'h00, 4'b0000, 8'h00, 4'b0010};
        vecs[8]  = '{4'd11, 4'hF, 8'h00, 8'h00, 4'b0000, 8'hFF, 4'b1000};
        vecs[9]  = '{4'd15, 4'hF, 8'h3C, 8'h99, 4'b1010, 8'h3C, 4'b1010};
        vecs[10] = '{4'd14, 4'hF, 8'h55, 8'h00, 4'b1101, 8'h00, 4'b0111};
        vecs[11] = '{4'd3,  4'hF, 8'hF0, 8'h0F, 4'b0000, 8'h00, 4'b0010};
        vecs[12] = '{4'd4,  4'hF, 8'h80, 8'h01, 4'b0001, 8'h81, 4'b1001};
        vecs[13] = '{4'd5,  4'hF, 8'hFF, 8'hFF, 4'b1000, 8'h00, 4'b0010};
        vecs[14] = '{4'd7,  4'hF, 8'h01, 8'h00, 4'b0000, 8'h00, 4'b0011};
        vecs[15] = '{4'd8,  4'hF, 8'h80, 8'h00, 4'b0100, 8'h00, 4'b0111};
        vecs[16] = '{4'd1,  4'hF, 8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0011};
        vecs[17] = '{4'd12, 4'hF, 8'h10, 8'h20, 4'b0000, 8'h10, 4'b1000};
        vecs[18] = '{4'd0,  4'hF, 8'h77, 8'h00, 4'b1111, 8'h77, 4'b1111};
        vecs[19] = '{4'd1,  4'h1, 8'h50, 8'h50, 4'b0110, 8'hA0, 4'b0110};
        vecs[20] = '{4'd2,  4'hF, 8'h80, 8'h01, 4'b0001, 8'h7F, 4'b0101};
        vecs[21] = '{4'd3,  4'h0, 8'hF0, 8'h0F, 4'b1111, 8'h00, 4'b1111};
        vecs[22] = '{4'd8,  4'hF, 8'h40, 8'h00, 4'b0001, 8'h81, 4'b1000};

        // All-zero inputs give zero outputs in both builds
        #2 rst_n = 1'b0;
        #1 check("reset", dut_out(), exp_t'(12'h000));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].mask,
                  vecs[i].lhs, vecs[i].rhs, vecs[i].fl,
                  {vecs[i].res, vecs[i].efl});
        end

        for (int i = 0; i < 300; i++) begin
            logic [3:0] op, m, fl;
            logic [7:0] l, r;
            op = 4'($urandom_range(0, 15));
            m  = 4'($urandom_range(0, 15));
            fl = 4'($urandom_range(0, 15));
            l  = 8'($urandom_range(0, 255));
            r  = 8'($urandom_range(0, 255));
            apply($sformatf("rand%0d_op%0d", i, op), op, m, l, r, fl,
                  model(op, m, l, r, fl));
        end

`ifdef CORE_ALU_OUTREG_EN
        @(negedge clk);
        en = 1'b1;
        drive(4'd1, 4'hF, 8'h50, 8'h50, 4'b0000);
        @(posedge clk); #1;
        check("reg_load", dut_out(), {8'hA0, 4'b1100});
        @(negedge clk);
        en = 1'b0;
        drive(4'd10, 4'hF, 8'hFF, 8'h00, 4'b0000);
        @(posedge clk); #1;
        check("reg_hold", dut_out(), {8'hA0, 4'b1100});
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        check("reg_update", dut_out(), {8'h00, 4'b0010});
        @(negedge clk);
        drive(4'd1, 4'hF, 8'h50, 8'h50, 4'b0000);
        #2 rst_n = 1'b0;
        #1 check("async_clear", dut_out(), exp_t'(12'h000));
        @(posedge clk); #1;
        check("clear_discard", dut_out(), exp_t'(12'h000));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("after_release", dut_out(), exp_t'(12'h000));
        @(posedge clk); #1;
        check("reg_resume", dut_out(), {8'hA0, 4'b1100});
`else
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        drive(4'd1, 4'hF, 8'h50, 8'h50, 4'b0000);
        #1 check("comb_ignore_ctl", dut_out(), {8'hA0, 4'b1100});
        drive(4'd9, 4'hF, 8'h01, 8'h00, 4'b0001);
        @(posedge clk); #1;
        check("comb_no_clock", dut_out(), {8'h80, 4'b1001});
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        drive(4'd6, 4'hF, 8'h80, 8'h00, 4'b0000);
        #1 check("comb_same_cycle", dut_out(), {8'h00, 4'b0011});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
